data_router_pp: RTL
===================

// Module: data_router_pp
// PURPOSE
//  Synthesizable, parametrised ping-pong data router feeding the PE array.
//  Sits between the input-feature SRAM loader and the POY x BUFW MAC array.
//  Two pages of POY banks x BUFH rows x BUFW words: the loader fills one page while the array reads the other.
//  Read commands: RR (one row, all banks), BR (one row, one bank), RP (one pixel, all banks).
// PARAMETERS
//  DW     32  data word width (bits)
//  POY    3   banks = output rows computed in parallel
//  BUFH   3   rows per bank (kernel height)
//  BUFW   32  words per row
//  CW     $clog2(BUFW)  column index width (derived localparam)
// PORTS
//  clk        in   1             clock, rising edge
//  rst_n      in   1             async active-low reset
//  wr_en      in   1             write one word (accepted only if wr_ready)
//  wr_data    in   DW            word; order col fastest, then row, then bank
//  wr_ready   out  1             write page not full
//  blkend     out  1             1-cycle pulse: last word of a page written
//  cmd_valid  in   1             read command valid
//  cmd_ready  out  1             read page full (readable)
//  cmd_mode   in   2             00 RR, 01 BR, 10 RP, 11 NE (no-op)
//  cmd_bank   in   8             bank index (BR)
//  cmd_row    in   8             row index (all modes)
//  cmd_col    in   CW            column index (RP)
//  rd_release in   1             pulse: reader done with read page
//  data_o     out  POY*BUFW*DW   registered array; lane [b][c] at ((b*BUFW)+c)*DW
//  out_valid  out  1             1-cycle pulse: data_o updated
// BEHAVIOUR
//  Reset: data_o=0, out_valid=0, blkend=0, wr_ready=1, cmd_ready=0,
//   both pages EMPTY, wr_page=0, rd_page=0, write counters 0; stored words not reset.
//  Page state per page: EMPTY -> (last write) FULL -> (rd_release while rd page) EMPTY.
//  Write: wr_en&&wr_ready stores wr_data at [wr_page][bank][row][col], col++;
//   col wraps at BUFW -> row++; row wraps at BUFH -> bank++.
//   Word POY*BUFH*BUFW-1: page FULL, blkend=1 next cycle, counters to 0, wr_page toggles.
//  wr_ready = page[wr_page]==EMPTY (combinational). wr_en while !wr_ready ignored.
//  Read accept: cmd_valid&&cmd_ready. cmd_ready = page[rd_page]==FULL. No output backpressure.
//  Latency: 1 cycle; data_o and out_valid update on the edge after accept.
//   RR: every bank b, data_o[b][*] <= mem[rd_page][b][row][*].
//   BR: only bank cmd_bank updated; other banks hold.
//   RP: for every b, only lane [b][cmd_col] updated; other lanes hold.
//   NE: accepted, no update, out_valid stays 0.
//  Out of range (row>=BUFH, or BR bank>=POY): accepted, no update, out_valid stays 0.
//  rd_release with read page FULL: page EMPTY, rd_page toggles; otherwise ignored.
//  Cmd accepted in the same cycle as rd_release: served from the old page, then released.
//  Last write and release in the same cycle on different pages: both take effect.
//  Reset mid-fill or mid-read: partial page discarded, state returns to reset values.
// CONFIGURATION
//  DATA_ROUTER_ERR_EN defined: extra port err_o (out, 1), 1-cycle pulse on the edge after accepting
//   an out-of-range command, or after wr_en while !wr_ready; reset 0.
//  Undefined: no err_o port; those events are silently ignored as above.
// TESTING (defaults; word written k-th within a page = page_base + k)
//  Reset, then 288 writes of 0..287 -> blkend pulse after word 287; wr_ready stays 1 (page1 empty);
//   cmd_ready=1.
//  RR row=1 -> next cycle out_valid=1; data_o[b][c] = b*96+32+c (e.g. [2][5]=229).
//  Zero data_o via RR row 0, then BR bank=1 row=2 -> only bank1 changes, [1][0]=160; RP row=0 col=7
//   -> lanes [b][7] = b*96+7, all others unchanged.
//  Fill page1 (1000+k), fill page0 again -> wr_ready=0 after 2nd blkend; extra wr_en dropped
//   (err_o=1 if ERR_EN); rd_release -> RR row 0 returns [0][0]=1000.
//  BR bank=3 and RR row=3 -> no data change, out_valid=0, err_o pulses if ERR_EN; NE -> no change.
//  Assert rst_n=0 after 100 writes -> all outputs reset; fresh 288 writes complete normally.

Source files
------------

// File: rtl/data_router_pp.sv
// Ping-pong data router: the loader fills one page of POY x BUFH x BUFW words while the MAC array reads the other.
// Define DATA_ROUTER_ERR_EN to add err_o, which pulses on dropped writes and out-of-range read commands.
module data_router_pp #(
  parameter int DW   = 32,
  parameter int POY  = 3,
  parameter int BUFH = 3,
  parameter int BUFW = 32,
  localparam int CW  = (BUFW > 1) ? $clog2(BUFW) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  output logic                     wr_ready,
  output logic                     blkend,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_mode,
  input  logic [7:0]               cmd_bank,
  input  logic [7:0]               cmd_row,
  input  logic [CW-1:0]            cmd_col,
  input  logic                     rd_release,
  output logic [POY*BUFW*DW-1:0]   data_o,
  output logic                     out_valid
`ifdef DATA_ROUTER_ERR_EN
  ,
  output logic                     err_o
`endif
);

  localparam int RW = (BUFH > 1) ? $clog2(BUFH) : 1;
  localparam int BW = (POY > 1) ? $clog2(POY) : 1;

  localparam logic [1:0] MODE_RR = 2'b00;
  localparam logic [1:0] MODE_BR = 2'b01;
  localparam logic [1:0] MODE_RP = 2'b10;
  localparam logic [1:0] MODE_NE = 2'b11;

  typedef enum logic {
    PG_EMPTY = 1'b0,
    PG_FULL  = 1'b1
  } page_st_t;

  page_st_t r_page_st [2];
  page_st_t w_page_nx [2];

  logic [DW-1:0] r_mem [2][POY][BUFH][BUFW];

  logic                   r_wr_page;
  logic                   r_rd_page;
  logic [CW-1:0]          r_wcol;
  logic [RW-1:0]          r_wrow;
  logic [BW-1:0]          r_wbank;
  logic [POY*BUFW*DW-1:0] r_data;
  logic                   r_out_valid;
  logic                   r_blkend;

  logic          w_wr_acc;
  logic          w_wr_last;
  logic          w_cmd_acc;
  logic          w_row_ok;
  logic          w_bank_ok;
  logic          w_rd_ok;
  logic          w_release;
  logic [RW-1:0] w_row;
  logic [BW-1:0] w_bank;

  // Handshakes: a write is taken when wr_en && wr_ready, a command when cmd_valid && cmd_ready;
  // both readies depend only on page state, never on the matching valid.
  assign wr_ready  = (r_page_st[r_wr_page] == PG_EMPTY);
  assign cmd_ready = (r_page_st[r_rd_page] == PG_FULL);

  assign w_wr_acc  = wr_en && wr_ready;
  assign w_wr_last = w_wr_acc && (r_wbank == BW'(POY - 1)) && (r_wrow == RW'(BUFH - 1))
                     && (r_wcol == CW'(BUFW - 1));
  assign w_cmd_acc = cmd_valid && cmd_ready;
  assign w_row_ok  = (cmd_row < 8'(BUFH));
  assign w_bank_ok = (cmd_mode != MODE_BR) || (cmd_bank < 8'(POY));
  assign w_rd_ok   = w_cmd_acc && w_row_ok && w_bank_ok && (cmd_mode != MODE_NE);
  assign w_release = rd_release && cmd_ready;
  assign w_row     = cmd_row[RW-1:0];
  assign w_bank    = cmd_bank[BW-1:0];

  // Write page is always EMPTY and read page FULL when they act, so these never collide.
  always_comb begin
    w_page_nx = r_page_st;
    if (w_release) w_page_nx[r_rd_page] = PG_EMPTY;
    if (w_wr_last) w_page_nx[r_wr_page] = PG_FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page_st[0] <= PG_EMPTY;
      r_page_st[1] <= PG_EMPTY;
    end else begin
      r_page_st <= w_page_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_page <= 1'b0;
      r_rd_page <= 1'b0;
      r_wcol    <= '0;
      r_wrow    <= '0;
      r_wbank   <= '0;
    end else begin
      if (w_release) r_rd_page <= ~r_rd_page;
      if (w_wr_last) begin
        r_wcol    <= '0;
        r_wrow    <= '0;
        r_wbank   <= '0;
        r_wr_page <= ~r_wr_page;
      end else if (w_wr_acc) begin
        if (r_wcol == CW'(BUFW - 1)) begin
          r_wcol <= '0;
          if (r_wrow == RW'(BUFH - 1)) begin
            r_wrow  <= '0;
            r_wbank <= r_wbank + 1'b1;
          end else begin
            r_wrow <= r_wrow + 1'b1;
          end
        end else begin
          r_wcol <= r_wcol + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_page][r_wbank][r_wrow][r_wcol] <= wr_data;
  end

  // A command issued alongside rd_release still sees the old r_rd_page here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_blkend    <= 1'b0;
    end else begin
      r_blkend    <= w_wr_last;
      r_out_valid <= w_rd_ok;
      if (w_rd_ok) begin
        for (int b = 0; b < POY; b++) begin
          for (int c = 0; c < BUFW; c++) begin
            if ((cmd_mode == MODE_RR) ||
                ((cmd_mode == MODE_BR) && (w_bank == BW'(b))) ||
                ((cmd_mode == MODE_RP) && (cmd_col == CW'(c)))) begin
              r_data[((b * BUFW) + c) * DW +: DW] <= r_mem[r_rd_page][b][w_row][c];
            end
          end
        end
      end
    end
  end

  assign data_o    = r_data;
  assign out_valid = r_out_valid;
  assign blkend    = r_blkend;

`ifdef DATA_ROUTER_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_cmd_acc && !(w_row_ok && w_bank_ok)) || (wr_en && !wr_ready);
    end
  end

  assign err_o = r_err;
`endif

endmodule
